// File: rtl/ov5640_frame_ctrl.sv
// Frame capture controller for an OV5640 feeding a double-buffered SDRAM frame store.
// Discards settling frames, writes whole frames into one bank and swaps banks on good frames.
module ov5640_frame_ctrl #(
    parameter int SETTLE_FRAMES = 10,
    parameter int FRAME_WORDS   = 786432,
    parameter int ADDR_W        = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_done,
    input  logic              init_done,
    input  logic              vsync,
    input  logic              pix_valid,
    input  logic              rd_lock,
    output logic              cap_en,
    output logic              sdram_wr_en,
    output logic [ADDR_W:0]   sdram_wr_addr,
    output logic              rd_bank,
    output logic              frame_done,
    output logic              frame_err,
    output logic [7:0]        drop_cnt,
    output logic [7:0]        err_cnt
);

    localparam int SET_W = $clog2(SETTLE_FRAMES + 2);
    // One extra bit so the offset can sit at FRAME_WORDS even when it equals 2^ADDR_W.
    localparam int OFF_W = ADDR_W + 1;
    localparam logic [OFF_W-1:0] FRAME_WORDS_V = OFF_W'(FRAME_WORDS);
    localparam logic [SET_W-1:0] SETTLE_LAST   = SET_W'(SETTLE_FRAMES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        ARM     = 2'd2,
        CAPTURE = 2'd3
    } state_t;

    state_t             state_reg;
    logic               vsync_d_reg;
    logic [SET_W-1:0]   settle_cnt_reg;
    logic [OFF_W-1:0]   offset_reg;
    logic               overrun_reg;
    logic               wr_bank_reg;
    logic               rd_bank_reg;
    logic               cap_en_reg;
    logic               frame_done_reg;
    logic               frame_err_reg;
    logic [7:0]         drop_cnt_reg;
    logic [7:0]         err_cnt_reg;

    logic vs_rise;
    logic run_ok;
    logic word_ok;
    logic frame_good;

    assign vs_rise    = vsync & ~vsync_d_reg;
    assign run_ok     = cfg_done & init_done;
    assign word_ok    = offset_reg < FRAME_WORDS_V;
    assign frame_good = (offset_reg == FRAME_WORDS_V) && !overrun_reg;

    // The write strobe follows pix_valid in the same cycle so no pixel buffering is needed.
    assign sdram_wr_en   = (state_reg == CAPTURE) && pix_valid && word_ok;
    assign sdram_wr_addr = {wr_bank_reg, offset_reg[ADDR_W-1:0]};
    assign cap_en        = cap_en_reg;
    assign rd_bank       = rd_bank_reg;
    assign frame_done    = frame_done_reg;
    assign frame_err     = frame_err_reg;
    assign drop_cnt      = drop_cnt_reg;
    assign err_cnt       = err_cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            vsync_d_reg    <= 1'b0;
            settle_cnt_reg <= '0;
            offset_reg     <= '0;
            overrun_reg    <= 1'b0;
            wr_bank_reg    <= 1'b0;
            rd_bank_reg    <= 1'b0;
            cap_en_reg     <= 1'b0;
            frame_done_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
            drop_cnt_reg   <= '0;
            err_cnt_reg    <= '0;
        end else begin
            vsync_d_reg    <= vsync;
            frame_done_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
            // Losing camera or SDRAM readiness abandons the partial frame silently.
            if (state_reg != IDLE && !run_ok) begin
                state_reg  <= IDLE;
                cap_en_reg <= 1'b0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (run_ok) begin
                            state_reg      <= SETTLE;
                            settle_cnt_reg <= '0;
                        end
                    end
                    SETTLE: begin
                        if (SETTLE_FRAMES == 0) begin
                            state_reg <= ARM;
                        end else if (vs_rise) begin
                            if (settle_cnt_reg == SETTLE_LAST)
                                state_reg <= ARM;
                            else
                                settle_cnt_reg <= settle_cnt_reg + 1'b1;
                        end
                    end
                    ARM: begin
                        if (vs_rise) begin
                            state_reg   <= CAPTURE;
                            offset_reg  <= '0;
                            overrun_reg <= 1'b0;
                            cap_en_reg  <= 1'b1;
                        end
                    end
                    CAPTURE: begin
                        if (vs_rise) begin
                            if (frame_good && !rd_lock) begin
                                rd_bank_reg    <= wr_bank_reg;
                                wr_bank_reg    <= ~wr_bank_reg;
                                frame_done_reg <= 1'b1;
                            end else if (frame_good) begin
                                if (drop_cnt_reg != 8'hFF)
                                    drop_cnt_reg <= drop_cnt_reg + 1'b1;
                            end else begin
                                frame_err_reg <= 1'b1;
                                if (err_cnt_reg != 8'hFF)
                                    err_cnt_reg <= err_cnt_reg + 1'b1;
                            end
                            offset_reg  <= '0;
                            overrun_reg <= 1'b0;
                        end else if (pix_valid) begin
                            if (word_ok)
                                offset_reg <= offset_reg + 1'b1;
                            else
                                overrun_reg <= 1'b1;
                        end
                    end
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ov5640_frame_ctrl.sv
// Directed plus randomized frame sequences against a frame-level model of the capture controller.
module tb_ov5640_frame_ctrl;

    localparam int SF = 2;
    localparam int FW = 16;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cfg_done = 1'b0;
    logic          init_done = 1'b0;
    logic          vsync = 1'b0;
    logic          pix_valid = 1'b0;
    logic          rd_lock = 1'b0;
    logic          cap_en;
    logic          sdram_wr_en;
    logic [AW:0]   sdram_wr_addr;
    logic          rd_bank;
    logic          frame_done;
    logic          frame_err;
    logic [7:0]    drop_cnt;
    logic [7:0]    err_cnt;

    int checks = 0;
    int errors = 0;

    // Frame-level model: vsync edges seen since enable, pixels in current frame, banks, counters.
    int m_vs = 0;
    bit m_cap = 1'b0;
    int m_pix = 0;
    int m_wr = 0;
    int m_rd = 0;
    int m_drop = 0;
    int m_err = 0;

    ov5640_frame_ctrl #(
        .SETTLE_FRAMES(SF),
        .FRAME_WORDS(FW),
        .ADDR_W(AW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cfg_done(cfg_done),
        .init_done(init_done),
        .vsync(vsync),
        .pix_valid(pix_valid),
        .rd_lock(rd_lock),
        .cap_en(cap_en),
        .sdram_wr_en(sdram_wr_en),
        .sdram_wr_addr(sdram_wr_addr),
        .rd_bank(rd_bank),
        .frame_done(frame_done),
        .frame_err(frame_err),
        .drop_cnt(drop_cnt),
        .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_cap_en"}, cap_en, 0);
        chk({tag, "_wr_en"}, sdram_wr_en, 0);
        chk({tag, "_wr_addr"}, sdram_wr_addr, 0);
        chk({tag, "_rd_bank"}, rd_bank, 0);
        chk({tag, "_done"}, frame_done, 0);
        chk({tag, "_err"}, frame_err, 0);
        chk({tag, "_drop_cnt"}, drop_cnt, 0);
        chk({tag, "_err_cnt"}, err_cnt, 0);
    endtask

    task automatic send_pixels(input int n);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                pix_valid = 1'b0;
                #1 chk("gap_wr_en", sdram_wr_en, 0);
                step();
            end
            pix_valid = 1'b1;
            #1;
            chk("wr_en", sdram_wr_en, (m_cap && m_pix < FW) ? 1 : 0);
            if (m_cap && m_pix < FW)
                chk("wr_addr", sdram_wr_addr, m_wr * FW + m_pix);
            chk("cap_en", cap_en, m_cap);
            if (m_cap) m_pix++;
            step();
        end
        pix_valid = 1'b0;
    endtask

    task automatic end_frame(input bit lock);
        bit exp_done = 1'b0;
        bit exp_fe = 1'b0;
        vsync = 1'b1;
        rd_lock = lock;
        step();
        vsync = 1'b0;
        rd_lock = 1'b0;
        m_vs++;
        if (m_cap) begin
            if (m_pix == FW) begin
                if (!lock) begin
                    m_rd = m_wr;
                    m_wr = 1 - m_wr;
                    exp_done = 1'b1;
                end else if (m_drop < 255) begin
                    m_drop++;
                end
            end else begin
                exp_fe = 1'b1;
                if (m_err < 255) m_err++;
            end
        end
        m_pix = 0;
        if (m_vs > SF) m_cap = 1'b1;
        chk("frame_done", frame_done, exp_done);
        chk("frame_err", frame_err, exp_fe);
        chk("rd_bank", rd_bank, m_rd);
        chk("drop_cnt", drop_cnt, m_drop);
        chk("err_cnt", err_cnt, m_err);
        chk("cap_en_vs", cap_en, m_cap);
        if (m_cap)
            chk("wr_bank", sdram_wr_addr, m_wr * FW);
        step();
        chk("done_pulse_end", frame_done, 0);
        chk("err_pulse_end", frame_err, 0);
    endtask

    initial begin
        #2;
        chk_all_zero("reset");
        step();
        step();
        rst = 1'b0;
        step();
        cfg_done = 1'b1;
        init_done = 1'b1;
        step();
        step();

        // Two settle frames, one armed frame, then two good frames alternating banks.
        for (int f = 0; f < 3; f++) begin
            send_pixels(FW);
            end_frame(1'b0);
        end
        send_pixels(FW);
        end_frame(1'b0);
        send_pixels(FW);
        end_frame(1'b0);

        // Short and long frames.
        send_pixels(FW - 1);
        end_frame(1'b0);
        send_pixels(FW + 1);
        end_frame(1'b0);

        // Good frame dropped under rd_lock, then the same bank is rewritten.
        send_pixels(FW);
        end_frame(1'b1);
        send_pixels(FW);
        end_frame(1'b0);

        for (int k = 0; k < 20; k++) begin
            int n;
            n = ($urandom_range(0, 9) < 6) ? FW : int'($urandom_range(FW - 2, FW + 2));
            send_pixels(n);
            end_frame($urandom_range(0, 3) == 0);
        end

        // Readiness lost mid-frame.
        send_pixels(5);
        pix_valid = 1'b1;
        init_done = 1'b0;
        step();
        chk("drop_cap_en", cap_en, 0);
        chk("drop_wr_en", sdram_wr_en, 0);
        chk("drop_done", frame_done, 0);
        chk("drop_err", frame_err, 0);
        chk("drop_err_cnt", err_cnt, m_err);
        chk("drop_drop_cnt", drop_cnt, m_drop);
        chk("drop_rd_bank", rd_bank, m_rd);
        pix_valid = 1'b0;
        m_vs = 0;
        m_cap = 1'b0;
        m_pix = 0;
        step();
        init_done = 1'b1;
        step();
        step();
        for (int f = 0; f < 3; f++) begin
            send_pixels(4);
            end_frame(1'b0);
        end
        send_pixels(FW);
        end_frame(1'b0);

        // Error counter saturation with empty frames.
        for (int k = 0; k < 300; k++)
            end_frame(1'b0);
        chk("err_cnt_sat", err_cnt, m_err);

        // Asynchronous reset in the middle of a captured frame.
        send_pixels(7);
        pix_valid = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        chk_all_zero("async_rst");
        step();
        rst = 1'b0;
        pix_valid = 1'b0;
        m_vs = 0;
        m_cap = 1'b0;
        m_pix = 0;
        m_wr = 0;
        m_rd = 0;
        m_drop = 0;
        m_err = 0;
        for (int f = 0; f < 3; f++) begin
            send_pixels(4);
            end_frame(1'b0);
        end
        send_pixels(FW);
        end_frame(1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL timeout: observed no completion expected finish");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ov5640_frame_ctrl.md
OV5640_FRAME_CTRL -- requirements
Module: ov5640_frame_ctrl

Interface
REQ-001 Parameter SETTLE_FRAMES, default 10: number of whole frames discarded after the camera is configured, before capture starts.
REQ-002 Parameter FRAME_WORDS, default 786432 (1024*768): number of 16-bit SDRAM words in one complete frame.
REQ-003 Parameter ADDR_W, default 20: width of the word offset inside one bank; FRAME_WORDS SHALL be <= 2^ADDR_W.
REQ-004 clk  in  1  single clock; all inputs are synchronous to it.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 cfg_done  in  1  camera register configuration complete (level).
REQ-007 init_done  in  1  SDRAM initialisation complete (level).
REQ-008 vsync  in  1  camera frame sync; its rising edge marks a frame boundary.
REQ-009 pix_valid  in  1  one 16-bit pixel word available this cycle.
REQ-010 rd_lock  in  1  display reader is currently using rd_bank; bank swaps are forbidden while high.
REQ-011 cap_en  out  1  enables the camera data path.
REQ-012 sdram_wr_en  out  1  write strobe to SDRAM write port.
REQ-013 sdram_wr_addr  out  ADDR_W+1  {wr_bank, word offset}.
REQ-014 rd_bank  out  1  bank holding the newest complete frame.
REQ-015 frame_done  out  1  one-cycle pulse: good frame committed (bank swapped).
REQ-016 frame_err  out  1  one-cycle pulse: captured frame had the wrong word count.
REQ-017 drop_cnt  out  8  saturating count of good frames discarded because rd_lock was high.
REQ-018 err_cnt  out  8  saturating count of frame_err pulses.

Function
REQ-019 vsync is registered once (vsync_d); vs_rise = vsync & ~vsync_d, evaluated in the same cycle.
REQ-020 FSM states: IDLE, SETTLE, ARM, CAPTURE.
REQ-021 IDLE: moves to SETTLE when cfg_done & init_done; settle counter cleared.
REQ-022 SETTLE: counts vs_rise; on the SETTLE_FRAMES-th vs_rise goes to ARM. If SETTLE_FRAMES=0, goes straight to ARM.
REQ-023 ARM: on vs_rise goes to CAPTURE, word offset cleared to 0, cap_en=1 from the next cycle.
REQ-024 CAPTURE: each pix_valid with offset < FRAME_WORDS asserts sdram_wr_en combinationally in the same cycle at the current address. Offset increments after the write.
REQ-025 CAPTURE: pix_valid with offset == FRAME_WORDS gives no write and sets an overrun flag. Offset does not wrap.
REQ-026 CAPTURE end, on vs_rise: the frame is good iff offset == FRAME_WORDS and overrun is clear.
REQ-027 Good frame with rd_lock low: rd_bank<=wr_bank, wr_bank<=~wr_bank, frame_done pulses for one cycle.
REQ-028 Good frame with rd_lock high: no swap, drop_cnt increments (saturating at 255), no frame_done.
REQ-029 Bad frame: no swap, frame_err pulses, err_cnt increments (saturating at 255).
REQ-030 The same vs_rise that ends a frame starts the next one: the FSM stays in CAPTURE, offset goes to 0, overrun is cleared.
REQ-031 If cfg_done or init_done goes low in any non-IDLE state, the FSM goes to IDLE on the next edge. The partial frame is discarded with no pulses and no counter change; cap_en and sdram_wr_en go low.
REQ-032 sdram_wr_en SHALL never be asserted outside CAPTURE.
REQ-033 frame_done and frame_err are never asserted together.

Reset
REQ-034 On rst, all of these go to 0 immediately: state=IDLE, cap_en, sdram_wr_en, sdram_wr_addr, wr_bank, rd_bank, frame_done, frame_err, drop_cnt, err_cnt, all internal counters and vsync_d.
REQ-035 After rst deasserts, operation resumes at the first clk edge.

Verification
REQ-036 SETTLE_FRAMES=2, FRAME_WORDS=16, both done high, 4 vsync pulses with 16 pix_valid per frame -> no writes before the 3rd vs_rise. Frame 1 writes addresses 0..15; frame_done then fires, rd_bank=0, wr_bank=1, and the next frame writes 16..31.
REQ-037 Frame with 15 pix_valid -> frame_err pulse, err_cnt=1, no swap. Frame with 17 pix_valid -> 16 writes, the 17th suppressed, frame_err pulse.
REQ-038 Good frame ends with rd_lock=1 -> drop_cnt=1, rd_bank unchanged, and the next frame rewrites the same bank from offset 0.
REQ-039 init_done dropped mid-CAPTURE -> cap_en=0 and sdram_wr_en=0 the next cycle, state IDLE, no pulse. Raising it again restarts SETTLE.
REQ-040 rst asserted mid-CAPTURE without a clk edge -> all outputs read 0 immediately. 300 bad frames -> err_cnt holds at 255.
